// File: rtl/mem_word_master_if.sv
// Bundle of core-side request signals and byte-wide external memory signals
// for mem_word_master.
interface mem_word_master_if #(
  parameter int WIDTH = 8
);
  // Handshake: req is a one-cycle strobe, taken only while busy=0 and halted=0;
  // it is ignored (not queued) otherwise. done pulses for one cycle per
  // accepted request, and rdata is valid from that pulse until the next read.
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [31:0]      wdata;
  logic             busy;
  logic             done;
  logic [31:0]      rdata;
  logic             halted;
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] mar;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;
  logic             kraj;
  logic [2:0]       dbg_state;

  modport master (
    input  req, we, addr, wdata, memdata, kraj,
    output busy, done, rdata, halted, memread, memwrite, mar, writedata,
           dbg_state
  );

  modport slave (
    output req, we, addr, wdata, memdata, kraj,
    input  busy, done, rdata, halted, memread, memwrite, mar, writedata,
           dbg_state
  );
endinterface

// File: rtl/mem_word_master.sv
// Splits 32-bit word reads/writes into four big-endian byte accesses on a
// byte-wide memory bus whose read data arrives one cycle after memread.
module mem_word_master #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  mem_word_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_t;

  state_t           state;
  logic [1:0]       cnt;
  logic [WIDTH-3:0] base_hi;
  logic [31:0]      wdata_q;
  logic [23:0]      rbuf;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    b = 8'h00;
    case (i)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      2'd3: b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign bus.dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      base_hi       <= '0;
      wdata_q       <= 32'h0;
      rbuf          <= 24'h0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.rdata     <= 32'h0;
      bus.halted    <= 1'b0;
      bus.memread   <= 1'b0;
      bus.memwrite  <= 1'b0;
      bus.mar       <= '0;
      bus.writedata <= '0;
    end else begin
      bus.halted <= bus.kraj;
      bus.done   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req && !bus.halted) begin
            base_hi  <= bus.addr[WIDTH-1:2];
            wdata_q  <= bus.wdata;
            cnt      <= 2'd0;
            bus.busy <= 1'b1;
            bus.mar  <= {bus.addr[WIDTH-1:2], 2'b00};
            if (bus.we) begin
              state         <= WRITE;
              bus.memwrite  <= 1'b1;
              bus.writedata <= WIDTH'(bus.wdata[31:24]);
            end else begin
              state       <= READ;
              bus.memread <= 1'b1;
            end
          end
        end
        READ: begin
          // memdata now carries the byte addressed one cycle earlier
          case (cnt)
            2'd1: rbuf[23:16] <= bus.memdata[7:0];
            2'd2: rbuf[15:8]  <= bus.memdata[7:0];
            2'd3: rbuf[7:0]   <= bus.memdata[7:0];
            default: ;
          endcase
          if (cnt == 2'd3) begin
            state       <= CAPT;
            bus.memread <= 1'b0;
          end else begin
            cnt     <= cnt + 2'd1;
            bus.mar <= {base_hi, cnt + 2'd1};
          end
        end
        CAPT: begin
          bus.rdata <= {rbuf, bus.memdata[7:0]};
          bus.done  <= 1'b1;
          state     <= DONE;
        end
        WRITE: begin
          if (cnt == 2'd3) begin
            state         <= DONE;
            bus.memwrite  <= 1'b0;
            bus.writedata <= '0;
            bus.done      <= 1'b1;
          end else begin
            cnt           <= cnt + 2'd1;
            bus.mar       <= {base_hi, cnt + 2'd1};
            bus.writedata <= WIDTH'(word_byte(wdata_q, cnt + 2'd1));
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_word_master.md
MEM_WORD_MASTER -- requirements
Module: mem_word_master

Interface
REQ-001 Parameter WIDTH, default 8: width of the byte-bus address and of the byte-bus data.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req  input  1  core request strobe, sampled only in IDLE.
REQ-005 we  input  1  1 = word write, 0 = word read; captured with req.
REQ-006 addr  input  WIDTH  word byte-address; addr[1:0] ignored and forced to 00.
REQ-007 wdata  input  32  write word; captured with req.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  assembled read word; valid while done=1 and held until the next read completes.
REQ-011 halted  output  1  registered copy of kraj.
REQ-012 memread  output  1  byte read strobe to external memory.
REQ-013 memwrite  output  1  byte write strobe to external memory.
REQ-014 mar  output  WIDTH  byte address to external memory.
REQ-015 writedata  output  WIDTH  byte write data to external memory.
REQ-016 memdata  input  WIDTH  byte read data; registered by memory, valid the cycle after memread.
REQ-017 kraj  input  1  sticky end-of-program flag from memory.

Function
REQ-018 The FSM SHALL have states IDLE, READ, CAPT, WRITE and DONE, with a 2-bit byte counter cnt.
REQ-019 In IDLE, if req=1 and halted=0, the block SHALL latch base={addr[WIDTH-1:2],2'b00}, we and wdata, clear cnt, and go to READ (we=0) or WRITE (we=1).
REQ-020 In IDLE with halted=1, req SHALL be ignored; the FSM stays in IDLE.
REQ-021 req asserted outside IDLE SHALL be ignored, with no queuing.
REQ-022 In READ: memread=1, mar=base|cnt; each cycle with cnt>=1 SHALL latch memdata into byte cnt-1 of rdata; cnt increments; after cnt=3 go to CAPT.
REQ-023 In CAPT: memread=0; latch memdata into byte 3; go to DONE.
REQ-024 Byte order SHALL be big-endian: byte 0 (mar[1:0]=00) maps to rdata[31:24], byte 3 to rdata[7:0].
REQ-025 In WRITE: memwrite=1, mar=base|cnt, writedata=wdata byte cnt (byte 0 = wdata[31:24]); cnt increments; after cnt=3 go to DONE.
REQ-026 In DONE: done=1 for exactly one cycle, then return to IDLE; a new req can be accepted in the following IDLE cycle.
REQ-027 Read latency: req accepted at edge 0; done is high in the 6th cycle after acceptance (4 READ cycles, 1 CAPT cycle, then DONE).
REQ-028 Write latency: done is high in the 5th cycle after acceptance.
REQ-029 memread and memwrite SHALL never be high in the same cycle, and both SHALL be 0 in IDLE, CAPT and DONE.
REQ-030 In IDLE, CAPT and DONE, mar SHALL hold its last driven value and writedata SHALL be 0.
REQ-031 halted SHALL update every cycle from kraj; an in-flight transaction SHALL complete normally if kraj rises mid-transaction.
REQ-032 The counter and address SHALL wrap within the word only; base is never incremented.

Reset
REQ-033 On reset: state=IDLE, cnt=0, busy=0, done=0, rdata=0, halted=0, memread=0, memwrite=0, mar=0, writedata=0.
REQ-034 Reset asserted mid-transaction SHALL abort it: strobes are low from the next cycle, no done pulse, and partial rdata is cleared.
REQ-035 After reset, halted SHALL re-assert one cycle later if kraj is still 1.

Verification
REQ-036 Memory word at mar 0x04 = 0xA1B2C3D4; read req, addr=0x04 -> mar sequence 04,05,06,07 with memread=1, then done=1 with rdata=0xA1B2C3D4.
REQ-037 Write req, addr=0x09, wdata=0x11223344 -> mar 08,09,0A,0B, writedata 11,22,33,44 with memwrite=1; a readback of 0x08 returns 0x11223344.
REQ-038 req held high continuously -> back-to-back transactions, each separated by exactly one IDLE cycle; done pulses are one cycle wide.
REQ-039 Reset asserted on the 3rd READ cycle -> next cycle memread=0, busy=0, rdata=0, and no done pulse.
REQ-040 Read of a word equal to 0xFFFFFFFF -> kraj rises; the transaction completes with done=1; halted=1; a subsequent req is ignored and busy stays 0.
